// File: rtl/timer_irq.sv
// Down-counting timer with one-shot / auto-reload modes and a masked level IRQ.
// Optional count prescaler is compiled in with `define TIMER_PRESCALE_EN.
module timer_irq #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;      // {IM, Mode[1:0], Enable}
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;
  logic        wr_ctrl, wr_preset, tick;

  assign wr_ctrl   = WE && (Addr == 2'd0);
  assign wr_preset = WE && (Addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PSW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PSW-1:0] ps_q;
  assign tick = (ps_q == PSW'(PRESCALE_DIV - 1));
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ps_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (ctrl_q[0]) state_q <= LOAD;
        LOAD: begin
          count_q    <= preset_q;
          irq_flag_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
          ps_q       <= '0;
`endif
          state_q    <= CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_q <= IDLE;
          end else begin
`ifdef TIMER_PRESCALE_EN
            ps_q <= tick ? '0 : ps_q + 1'b1;
`endif
            if (tick) begin
              // PRESET of 0 lands here on the first tick, same as PRESET of 1
              if (count_q > 32'd1) begin
                count_q <= count_q - 32'd1;
              end else begin
                count_q    <= '0;
                irq_flag_q <= 1'b1;
                state_q    <= INT;
              end
            end
          end
        end
        INT: begin
          if (ctrl_q[2:1] == 2'b01) begin
            irq_flag_q <= 1'b0;
            state_q    <= LOAD;
          end else begin
            ctrl_q[0] <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // CPU writes come last so they override same-edge FSM updates
      if (wr_ctrl) begin
        ctrl_q     <= Din[3:0];
        irq_flag_q <= 1'b0;
      end
      if (wr_preset) preset_q <= Din;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      2'd0:    Dout = {28'd0, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed scenarios plus random bus traffic against a
// reference model that tracks the timer as remaining-ticks / schedule counters.
module tb_timer_irq;
  localparam int unsigned DIV = 4;

  logic        clk, reset, WE, IRQ;
  logic [1:0]  Addr;
  logic [31:0] Din, Dout;

  int n_chk = 0;
  int n_pass = 0;

  timer_irq #(.PRESCALE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE),
    .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // run: 0 stopped, 1 reload pending, 2 counting, 3 just expired
  bit          m_en, m_im;
  bit [1:0]    m_mode;
  bit [31:0]   m_preset, m_count;
  bit          m_flag;
  int          m_run;
  int          m_sub;   // sub-ticks elapsed toward next count step

  function automatic int sub_per_tick();
`ifdef TIMER_PRESCALE_EN
    return DIV;
`else
    return 1;
`endif
  endfunction

  function automatic void m_reset();
    m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0;
    m_flag = 0; m_run = 0; m_sub = 0;
  endfunction

  function automatic void m_edge(bit we, bit [1:0] a, bit [31:0] d);
    bit en_n = m_en;
    int run_n = m_run;
    bit [31:0] cnt_n = m_count;
    bit flag_n = m_flag;
    int sub_n = m_sub;
    if (m_run == 0) begin
      if (m_en) run_n = 1;
    end else if (m_run == 1) begin
      cnt_n = m_preset; flag_n = 0; sub_n = 0; run_n = 2;
    end else if (m_run == 2) begin
      if (!m_en) run_n = 0;
      else if (m_sub + 1 < sub_per_tick()) sub_n = m_sub + 1;
      else begin
        sub_n = 0;
        if (m_count >= 2) cnt_n = m_count - 1;
        else begin cnt_n = 0; flag_n = 1; run_n = 3; end
      end
    end else begin
      if (m_mode == 2'b01) begin flag_n = 0; run_n = 1; end
      else begin en_n = 0; run_n = 0; end
    end
    m_en = en_n; m_run = run_n; m_count = cnt_n; m_flag = flag_n; m_sub = sub_n;
    if (we && a == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
    end
    if (we && a == 2'd1) m_preset = d;
  endfunction

  function automatic bit [31:0] m_read(int a);
    case (a)
      0: return {28'd0, m_im, m_mode, m_en};
      1: return m_preset;
      2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a; #1; v = Dout;
  endtask

  // One clock: present bus inputs, take the edge, then compare everything.
  task automatic cyc(bit we, bit [1:0] a, bit [31:0] d);
    logic [31:0] v;
    WE = we; Addr = a; Din = d;
    @(posedge clk);
    m_edge(we, a, d);
    #1;
    WE = 0;
    chk("irq", {31'd0, IRQ}, {31'd0, m_flag & m_im});
    for (int r = 0; r < 3; r++) begin
      rd(r[1:0], v);
      chk($sformatf("dout%0d", r), v, m_read(r));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, 32'd0);
  endtask

  // Reset asserted between edges; everything must clear without a clock.
  task automatic do_reset(string tag);
    logic [31:0] v;
    #2;
    reset = 0;
    m_reset();
    #1;
    chk({tag, "_irq"}, {31'd0, IRQ}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      rd(r[1:0], v);
      chk($sformatf("%s_dout%0d", tag, r), v, 32'd0);
    end
    @(posedge clk); @(posedge clk);
    #2;
    reset = 1;
  endtask

  initial begin
    logic [31:0] v;
    WE = 0; Addr = 0; Din = 0;
    reset = 0;
    m_reset();
    #1;
    chk("por_irq", {31'd0, IRQ}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      rd(r[1:0], v);
      chk($sformatf("por_dout%0d", r), v, 32'd0);
    end
    @(posedge clk); #2; reset = 1;
    idle(3);

    // mid-count reset, then stay idle afterwards
    cyc(1, 2'd1, 32'd100);
    cyc(1, 2'd0, 32'h9);
    idle(10);
    do_reset("rst_mid");
    idle(4);
    rd(2'd2, v); chk("rst_idle_count", v, 32'd0);

    // one-shot, PRESET=5
    cyc(1, 2'd1, 32'd5);
    cyc(1, 2'd0, 32'h9);
    idle(6);
    chk("os_pre_irq", {31'd0, IRQ}, 32'd0);
    idle(1);
    chk("os_irq", {31'd0, IRQ}, 32'd1);
    rd(2'd2, v); chk("os_count", v, 32'd0);
    idle(1);
    rd(2'd0, v); chk("os_ctrl", v, 32'h8);
    idle(3);
    chk("os_irq_hold", {31'd0, IRQ}, 32'd1);
    cyc(1, 2'd0, 32'h8);
    chk("os_irq_clr", {31'd0, IRQ}, 32'd0);

    // IRQ high, then reset drops it asynchronously
    cyc(1, 2'd1, 32'd1);
    cyc(1, 2'd0, 32'h9);
    idle(4);
    chk("pre_rst_irq", {31'd0, IRQ}, 32'd1);
    do_reset("rst_irq");
    idle(2);

    // auto-reload, PRESET=3: pulse every 5 cycles
    cyc(1, 2'd1, 32'd3);
    cyc(1, 2'd0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      idle(1);
      chk($sformatf("ar_k%0d", k), {31'd0, IRQ}, {31'd0, (k % 5) == 0});
    end
    cyc(1, 2'd0, 32'h0);
    idle(3);

    // masked one-shot
    cyc(1, 2'd1, 32'd2);
    cyc(1, 2'd0, 32'h1);
    idle(6);
    chk("mask_irq", {31'd0, IRQ}, 32'd0);
    rd(2'd2, v); chk("mask_count", v, 32'd0);
    cyc(1, 2'd0, 32'h8);
    chk("mask_irq_after", {31'd0, IRQ}, 32'd0);

    // disable freezes, re-enable reloads from new PRESET
    cyc(1, 2'd1, 32'd10);
    cyc(1, 2'd0, 32'h1);
    idle(3);
    cyc(1, 2'd0, 32'h0);
    idle(3);
    rd(2'd2, v); chk("freeze_count", v, 32'd8);
    cyc(1, 2'd1, 32'd20);
    rd(2'd2, v); chk("preset_no_touch", v, 32'd8);
    cyc(1, 2'd0, 32'h1);
    idle(2);
    rd(2'd2, v); chk("reload_count", v, 32'd20);

    // PRESET=0 behaves like 1; writes to COUNT / offset 3 are ignored
    cyc(1, 2'd0, 32'h0);
    idle(3);
    cyc(1, 2'd1, 32'd0);
    cyc(1, 2'd2, 32'hDEAD);
    cyc(1, 2'd3, 32'hBEEF);
    cyc(1, 2'd0, 32'hFFFF_FFF9);
    rd(2'd0, v); chk("ctrl_upper", v, 32'h9);
    idle(2 + sub_per_tick());
    chk("p0_irq", {31'd0, IRQ}, 32'd1);
    cyc(1, 2'd0, 32'h8);

`ifdef TIMER_PRESCALE_EN
    cyc(1, 2'd1, 32'd2);
    cyc(1, 2'd0, 32'h9);
    idle(9);
    chk("ps_pre_irq", {31'd0, IRQ}, 32'd0);
    idle(1);
    chk("ps_irq", {31'd0, IRQ}, 32'd1);
    cyc(1, 2'd0, 32'h8);
`endif

    // random bus traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 7) begin
        bit [31:0] d = $urandom;
        d[0] = ($urandom_range(0, 3) != 0);
        cyc(1, 2'd0, d);
      end else if (r < 13) cyc(1, 2'd1, $urandom_range(0, 6));
      else if (r < 16) cyc(1, 2'($urandom_range(2, 3)), $urandom);
      else if (r < 17) begin
        do_reset("rnd_rst");
        idle(1);
      end else idle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
